// File: rtl/secure_serdes_decryptor.sv
// Serial-in/parallel-out receiver: plaintext bit = c_bit ^ k_bit, MSB first, into a one-deep valid/ready holding register.
// Optional trailing even-parity bit when SERDES_PARITY_EN is defined.
module secure_serdes_decryptor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             c_bit,
  input  logic             k_bit,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             busy,
  output logic             ovr,
  output logic             perr
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
`ifdef SERDES_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic             start_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             startDet, dBit, done;
  logic [WIDTH-1:0] word;
`ifdef SERDES_PARITY_EN
  logic             perr_q, perr_d;
`endif

  assign startDet = start & ~start_q;
  assign dBit     = c_bit ^ k_bit;

  // Frame sequencing; dropping start on any capture edge aborts the frame silently.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    done    = 1'b0;
    word    = sr_q;
    case (state_q)
      IDLE: begin
        if (startDet) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sr_d    = '0;
        end
      end
      SHIFT: begin
        if (!start) begin
          state_d = IDLE;
        end else begin
          sr_d  = {sr_q[WIDTH-2:0], dBit};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SERDES_PARITY_EN
            state_d = PARITY;
`else
            state_d = IDLE;
            done    = 1'b1;
            word    = {sr_q[WIDTH-2:0], dBit};
`endif
          end
        end
      end
`ifdef SERDES_PARITY_EN
      PARITY: begin
        state_d = IDLE;
        done    = start;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Holding register: a completion that meets an unaccepted word is dropped and flagged.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
`ifdef SERDES_PARITY_EN
    perr_d  = perr_q;
`endif
    if (valid_q && out_ready) valid_d = 1'b0;
    if (done) begin
      if (valid_q && !out_ready) begin
        ovr_d = 1'b1;
      end else begin
        data_d  = word;
        valid_d = 1'b1;
`ifdef SERDES_PARITY_EN
        perr_d  = (^word) ^ c_bit;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      cnt_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SERDES_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      start_q <= start;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef SERDES_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = (state_q != IDLE);
  assign ovr       = ovr_q;
`ifdef SERDES_PARITY_EN
  assign perr      = perr_q;
`else
  assign perr      = 1'b0;
`endif

endmodule

// File: tb/tb_secure_serdes_decryptor.sv
// Directed bench for secure_serdes_decryptor (WIDTH=8) with a queue scoreboard of accepted words.
// Parity steps are included when SERDES_PARITY_EN is defined.
module tb_secure_serdes_decryptor;

  logic       clk;
  logic       rst;
  logic       start;
  logic       c_bit;
  logic       k_bit;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       busy;
  logic       ovr;
  logic       perr;

  int tests;
  int failed;
  logic [7:0] expQ[$];
  logic [7:0] expWord;

  secure_serdes_decryptor #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .c_bit     (c_bit),
    .k_bit     (k_bit),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .ovr       (ovr),
    .perr      (perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every handshake must match the oldest word the stimulus said would be loaded.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      tests++;
      if (expQ.size() == 0) begin
        failed++;
        $error("[TB] FAIL unexpected_word: observed %0h expected none", out_data);
      end else begin
        expWord = expQ.pop_front();
        assert (out_data === expWord) else begin
          failed++;
          $error("[TB] FAIL accepted_word: observed %0h expected %0h", out_data, expWord);
        end
      end
    end
  end

  // Drives one frame: detect edge, 8 keyed bits MSB first, then the parity bit if enabled.
  task automatic applyStimulus(input logic [7:0] c, input logic [7:0] k, input logic p,
                               input bit pushExp, input bit chkLat);
    if (pushExp) expQ.push_back(c ^ k);
    start = 1'b1;
    tick;
    checkOutput("busy_after_start", busy, 1);
    for (int i = 7; i >= 0; i--) begin
      c_bit = c[i];
      k_bit = k[i];
`ifndef SERDES_PARITY_EN
      if (chkLat && i == 0) checkOutput("no_early_valid", out_valid, 0);
`endif
      tick;
    end
`ifdef SERDES_PARITY_EN
    c_bit = p;
    k_bit = 1'b1;
    if (chkLat) checkOutput("no_early_valid", out_valid, 0);
    tick;
`else
    if (p) c_bit = 1'b0;
`endif
    c_bit = 1'b0;
    k_bit = 1'b0;
  endtask

  initial begin
    tests     = 0;
    failed    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    c_bit     = 1'b0;
    k_bit     = 1'b0;
    out_ready = 1'b1;
    #3;
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ovr", ovr, 0);
    checkOutput("rst_perr", perr, 0);
    tick;
    rst = 1'b0;
    tick;

    // Basic decode: 0x99 ^ 0x5A = 0xC3
    applyStimulus(8'h99, 8'h5A, 1'b0, 1'b1, 1'b1);
    checkOutput("basic_valid", out_valid, 1);
    checkOutput("basic_data", out_data, 32'hC3);
    checkOutput("basic_busy", busy, 0);
    checkOutput("basic_ovr", ovr, 0);
    checkOutput("basic_perr", perr, 0);
    tick;
    checkOutput("basic_valid_pulse", out_valid, 0);
    start = 1'b0;
    tick;

    // Backpressure: first word held, second dropped with overrun
    out_ready = 1'b0;
    applyStimulus(8'h3C ^ 8'h77, 8'h77, 1'b0, 1'b1, 1'b0);
    checkOutput("bp_first_valid", out_valid, 1);
    checkOutput("bp_first_ovr", ovr, 0);
    start = 1'b0;
    tick;
    applyStimulus(8'h11 ^ 8'hE1, 8'hE1, 1'b0, 1'b0, 1'b0);
    checkOutput("ovr_set", ovr, 1);
    checkOutput("ovr_data_held", out_data, 32'h3C);
    checkOutput("ovr_valid_held", out_valid, 1);
    start = 1'b0;
    out_ready = 1'b1;
    tick;
    checkOutput("bp_valid_cleared", out_valid, 0);
    checkOutput("ovr_sticky", ovr, 1);

    // Abort after 4 bits, then a full 0xA5 frame
    start = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      c_bit = i[0];
      k_bit = 1'b0;
      tick;
    end
    start = 1'b0;
    tick;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_no_valid", out_valid, 0);
    tick;
    checkOutput("abort_still_no_valid", out_valid, 0);
    applyStimulus(8'hA5 ^ 8'hC6, 8'hC6, 1'b0, 1'b1, 1'b1);
    checkOutput("abort_next_data", out_data, 32'hA5);
    checkOutput("abort_next_valid", out_valid, 1);
    start = 1'b0;
    tick;

    // Restart guard: start held high ~20 cycles yields one word
    applyStimulus(8'h5E ^ 8'h29, 8'h29, 1'b0, 1'b1, 1'b0);
    checkOutput("guard_data", out_data, 32'h5E);
    for (int i = 0; i < 11; i++) begin
      tick;
      checkOutput("guard_busy_low", busy, 0);
      checkOutput("guard_no_valid", out_valid, 0);
    end
    start = 1'b0;
    tick;

    // Reset mid-frame with a pending unaccepted word
    out_ready = 1'b0;
    applyStimulus(8'h42 ^ 8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0);
    checkOutput("pending_valid", out_valid, 1);
    start = 1'b0;
    tick;
    start = 1'b1;
    tick;
    for (int i = 0; i < 5; i++) begin
      c_bit = 1'b1;
      k_bit = 1'b0;
      tick;
    end
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_data", out_data, 0);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_ovr", ovr, 0);
    checkOutput("midrst_perr", perr, 0);
    start = 1'b0;
    tick;
    rst = 1'b0;
    out_ready = 1'b1;
    tick;
    applyStimulus(8'hFF ^ 8'h33, 8'h33, 1'b0, 1'b1, 1'b1);
    checkOutput("postrst_data", out_data, 32'hFF);
    checkOutput("postrst_valid", out_valid, 1);
    checkOutput("postrst_ovr", ovr, 0);
    start = 1'b0;
    tick;

`ifdef SERDES_PARITY_EN
    // 0xC3 has even weight: perr follows the parity bit directly
    applyStimulus(8'h99, 8'h5A, 1'b0, 1'b1, 1'b1);
    checkOutput("par0_data", out_data, 32'hC3);
    checkOutput("par0_perr", perr, 0);
    start = 1'b0;
    tick;
    applyStimulus(8'h99, 8'h5A, 1'b1, 1'b1, 1'b1);
    checkOutput("par1_data", out_data, 32'hC3);
    checkOutput("par1_perr", perr, 1);
    start = 1'b0;
    tick;
`endif

    tick;
    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
